// File: rtl/capture_pkg.sv
// capture_pkg: shared constants and helpers for the capture-side
// synchroniser bank.
//   STAGES_MIN/STAGES_MAX : legal synchroniser depth
//   STABLE_MIN/STABLE_MAX : legal bus stability count
//   clog2()               : ceiling log2 for elaboration-time widths
//   cnt_width()           : width of the bus stability counter
package capture_pkg;

    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 4;
    localparam int STABLE_MIN = 1;
    localparam int STABLE_MAX = 15;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return r;
    endfunction

    // Counter has to hold 0..STABLE inclusive.
    function automatic int cnt_width(input int stable);
        int w;
        w = clog2(stable + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain: W parallel flop chains of STAGES flops each, bringing
// asynchronous inputs into the clock_i domain.
//   clock_i  : destination clock
//   reset_ni : asynchronous active-low reset, clears every stage
//   d_a_i    : asynchronous input bits
//   q_o      : synchronised bits (last stage)
module sync_chain #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clock_i,
    input  logic         reset_ni,
    input  logic [W-1:0] d_a_i,
    output logic [W-1:0] q_o
);

    // Stage flops must stay distinct and adjacent; no logic between them.
    (* NOMERGE = "TRUE" *) logic [STAGES-1:0][W-1:0] r_stg;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_stg <= '0;
        end else begin
            r_stg[0] <= d_a_i;
            for (int i = 1; i < STAGES; i++) r_stg[i] <= r_stg[i-1];
        end
    end

    assign q_o = r_stg[STAGES-1];

endmodule

// File: rtl/capture_sync_bank.sv
// capture_sync_bank: receive-side synchroniser bank for one destination
// domain.
//   clock_i, reset_ni : destination clock, async active-low reset
//   level_a_i/level_o : WIDTH async levels in, synced (optionally
//                       glitch-filtered) levels out
//   rise_o/fall_o     : registered one-cycle edge pulses of level_o
//   bus_a_i/bus_o     : BBITS quasi-static bus in, committed value out
//   bus_valid_o       : one-cycle pulse when bus_o takes a new value
//   bus_settling_o    : synced bus not yet stable or not yet committed
module capture_sync_bank
    import capture_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               BBITS     = 4,
    parameter int               STAGES    = 2,
    parameter int               STABLE    = 3,
    parameter logic [WIDTH-1:0] FILTER    = '0,
    parameter logic [BBITS-1:0] RESET_BUS = '0,
    parameter int               DELAY     = 3
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic [WIDTH-1:0] level_a_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    input  logic [BBITS-1:0] bus_a_i,
    output logic [BBITS-1:0] bus_o,
    output logic             bus_valid_o,
    output logic             bus_settling_o
);

    localparam int             CW       = cnt_width(STABLE);
    localparam logic [CW-1:0]  STABLE_C = CW'(STABLE);

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("capture_sync_bank: STAGES=%0d out of range", STAGES);
    end
    if (STABLE < STABLE_MIN || STABLE > STABLE_MAX) begin : g_bad_stable
        $error("capture_sync_bank: STABLE=%0d out of range", STABLE);
    end
    // DELAY only shapes behavioural sim models; these flops carry no delay.
    if (DELAY < 0) begin : g_bad_delay
        $error("capture_sync_bank: DELAY=%0d negative", DELAY);
    end

    logic [WIDTH-1:0] w_slv;
    logic [BBITS-1:0] w_sbus;

    sync_chain #(.W(WIDTH), .STAGES(STAGES)) u_sync_lvl (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .d_a_i    (level_a_i),
        .q_o      (w_slv)
    );

    sync_chain #(.W(BBITS), .STAGES(STAGES)) u_sync_bus (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .d_a_i    (bus_a_i),
        .q_o      (w_sbus)
    );

    // Level path. A filtered channel passes s_lvl only when it agrees with
    // the previous sample, otherwise it holds; a one-sample excursion is
    // never seen. Unfiltered channels pass s_lvl straight through.
    logic [WIDTH-1:0] r_prev_lvl, r_flt_lvl, r_lvl_q;
    logic [WIDTH-1:0] w_hold, w_lvl;

    assign w_hold  = FILTER & (w_slv ^ r_prev_lvl);
    assign w_lvl   = (w_hold & r_flt_lvl) | (~w_hold & w_slv);
    assign level_o = w_lvl;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_prev_lvl <= '0;
            r_flt_lvl  <= '0;
            r_lvl_q    <= '0;
            rise_o     <= '0;
            fall_o     <= '0;
        end else begin
            r_prev_lvl <= w_slv;
            r_flt_lvl  <= w_lvl;
            r_lvl_q    <= w_lvl;
            rise_o     <= w_lvl & ~r_lvl_q;
            fall_o     <= ~w_lvl & r_lvl_q;
        end
    end

    // Bus path: count consecutive equal synced samples, commit once the
    // count is full and the value differs from what is already committed.
    logic [BBITS-1:0] r_pbus, r_bus;
    logic [CW-1:0]    r_cnt;
    logic             r_vld, r_settle;
    logic             w_eq, w_full, w_commit;

    assign w_eq     = (w_sbus == r_pbus);
    assign w_full   = (r_cnt == STABLE_C);
    assign w_commit = w_full & w_eq & (w_sbus != r_bus);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_pbus   <= '0;
            r_cnt    <= '0;
            r_bus    <= RESET_BUS;
            r_vld    <= 1'b0;
            r_settle <= 1'b0;
        end else begin
            r_pbus <= w_sbus;
            if (!w_eq)                r_cnt <= '0;
            else if (r_cnt < STABLE_C) r_cnt <= r_cnt + CW'(1);
            if (w_commit) r_bus <= w_sbus;
            r_vld    <= w_commit;
            r_settle <= ~w_full | (w_sbus != r_bus);
        end
    end

    assign bus_o          = r_bus;
    assign bus_valid_o    = r_vld;
    assign bus_settling_o = r_settle;

endmodule

// File: tb/tb_capture_sync_bank.sv
module tb_capture_sync_bank;

    localparam int         WIDTH     = 8;
    localparam int         BBITS     = 4;
    localparam int         STAGES    = 2;
    localparam int         STABLE    = 3;
    localparam logic [7:0] FILTER    = 8'h01;
    localparam logic [3:0] RESET_BUS = 4'h0;
    localparam int         N         = 2048;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] lvl_a = '0;
    logic [BBITS-1:0] bus_a = '0;
    logic [WIDTH-1:0] level_o, rise_o, fall_o;
    logic [BBITS-1:0] bus_o;
    logic             bus_valid_o, bus_settling_o;

    capture_sync_bank #(
        .WIDTH(WIDTH), .BBITS(BBITS), .STAGES(STAGES), .STABLE(STABLE),
        .FILTER(FILTER), .RESET_BUS(RESET_BUS), .DELAY(3)
    ) dut (
        .clock_i        (clk),
        .reset_ni       (rst_n),
        .level_a_i      (lvl_a),
        .level_o        (level_o),
        .rise_o         (rise_o),
        .fall_o         (fall_o),
        .bus_a_i        (bus_a),
        .bus_o          (bus_o),
        .bus_valid_o    (bus_valid_o),
        .bus_settling_o (bus_settling_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Edges since reset release; after edge k, cyc == k.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // History of inputs: lx[m]/bx[m] is what edge m sampled.
    logic [WIDTH-1:0] lx [N];
    logic [BBITS-1:0] bx [N];
    initial forever begin
        @(posedge clk);
        if (cyc + 1 < N) begin
            lx[cyc+1] = lvl_a;
            bx[cyc+1] = bus_a;
        end
    end

    // Reference model over histories. Index m = state visible between
    // edge m-1 and edge m (m=1 is the reset state).
    logic [WIDTH-1:0] slv [N];
    logic [WIDTH-1:0] lvm [N];
    logic [BBITS-1:0] sb  [N];
    logic [BBITS-1:0] busm[N];
    bit               eqp [N];

    // True when the last STABLE synced-sample pairs before m all matched.
    function automatic bit stable_before(input int m);
        if (m - STABLE < 1) return 1'b0;
        for (int i = 1; i <= STABLE; i++) if (!eqp[m-i]) return 1'b0;
        return 1'b1;
    endfunction

    initial forever begin
        int               m;
        logic [WIDTH-1:0] rise_e, fall_e;
        bit               vld_e, set_e, commit;
        logic [7:0]       fmask;
        @(negedge clk);
        if (rst_n && cyc + 1 < N) begin
            m     = cyc + 1;
            fmask = FILTER;
            if (m == 1) begin
                sb[0] = '0; slv[0] = '0; lvm[0] = '0;
            end
            sb[m]  = (m - STAGES >= 1) ? bx[m-STAGES] : '0;
            slv[m] = (m - STAGES >= 1) ? lx[m-STAGES] : '0;
            eqp[m] = (sb[m] == sb[m-1]);
            for (int k = 0; k < WIDTH; k++)
                lvm[m][k] = (fmask[k] && slv[m][k] != slv[m-1][k]) ? lvm[m-1][k] : slv[m][k];
            if (m == 1) begin
                rise_e = '0; fall_e = '0;
                busm[1] = RESET_BUS; vld_e = 1'b0; set_e = 1'b0;
            end else begin
                rise_e  = lvm[m-1] & ~lvm[m-2];
                fall_e  = ~lvm[m-1] & lvm[m-2];
                commit  = stable_before(m-1) && eqp[m-1] && (sb[m-1] != busm[m-1]);
                busm[m] = commit ? sb[m-1] : busm[m-1];
                vld_e   = commit;
                set_e   = !stable_before(m-1) || (sb[m-1] != busm[m-1]);
            end
            chk("mdl_level",  level_o,        lvm[m]);
            chk("mdl_rise",   rise_o,         rise_e);
            chk("mdl_fall",   fall_o,         fall_e);
            chk("mdl_bus",    bus_o,          busm[m]);
            chk("mdl_valid",  bus_valid_o,    vld_e);
            chk("mdl_settle", bus_settling_o, set_e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt_a, cnt_b, cnt_c;
        bit seen;
        logic [3:0] vld_h [16];
        logic [3:0] bus_h [16];
        logic       set_h [16];

        // reset state while held
        repeat (3) tick();
        chk("rst_level", level_o, 0);
        chk("rst_rise",  rise_o, 0);
        chk("rst_bus",   bus_o, RESET_BUS);
        chk("rst_settle", bus_settling_o, 0);
        rst_n = 1'b1;
        repeat (10) tick();

        // 1: rise and fall on unfiltered... channel 0 is filtered, so use
        // channel 2 for the plain path latency.
        lvl_a[2] = 1'b1;
        tick(); chk("t1_lvl_e1", level_o[2], 0);
        tick(); chk("t1_lvl_e2", level_o[2], 1); chk("t1_rise_e2", rise_o[2], 0);
        tick(); chk("t1_rise_e3", rise_o[2], 1);
        tick(); chk("t1_rise_e4", rise_o[2], 0);
        lvl_a[2] = 1'b0;
        cnt_a = 0;
        repeat (6) begin tick(); cnt_a += int'(fall_o[2]); end
        chk("t1_fall_cnt", cnt_a, 1);

        // 2: one-cycle glitch on filtered ch0 and unfiltered ch1
        lvl_a[1:0] = 2'b11;
        tick();
        lvl_a[1:0] = 2'b00;
        seen = 1'b0; cnt_a = 0; cnt_b = 0;
        repeat (8) begin
            tick();
            seen |= level_o[0] | rise_o[0];
            cnt_a += int'(rise_o[1]);
            cnt_b += int'(fall_o[1]);
        end
        chk("t2_ch0_quiet", seen, 0);
        chk("t2_ch1_rise",  cnt_a, 1);
        chk("t2_ch1_fall",  cnt_b, 1);

        // 3: bus 0 -> A, commit at edge 7
        chk("t3_idle_settle", bus_settling_o, 0);
        bus_a = 4'hA;
        for (int e = 1; e <= 9; e++) begin
            tick();
            vld_h[e] = {3'b0, bus_valid_o}; bus_h[e] = bus_o; set_h[e] = bus_settling_o;
        end
        chk("t3_set_e2", set_h[2], 0);
        chk("t3_set_e3", set_h[3], 1);
        chk("t3_set_e7", set_h[7], 1);
        chk("t3_set_e8", set_h[8], 0);
        chk("t3_vld_e6", vld_h[6], 0);
        chk("t3_vld_e7", vld_h[7], 1);
        chk("t3_vld_e8", vld_h[8], 0);
        chk("t3_bus_e6", bus_h[6], 4'h0);
        chk("t3_bus_e7", bus_h[7], 4'hA);

        // 4: 3/5 toggling every 2 cycles, then hold 5
        cnt_a = 0; seen = 1'b0;
        for (int i = 0; i < 35; i++) begin
            bus_a = (i < 20 && ((i / 2) % 2) == 0) ? 4'h3 : 4'h5;
            tick();
            cnt_a += int'(bus_valid_o);
            seen  |= (bus_o == 4'h3);
        end
        chk("t4_commits", cnt_a, 1);
        chk("t4_no_3",    seen, 0);
        chk("t4_bus",     bus_o, 4'h5);

        // 5: excursion 0 -> 6 -> 0 before commit
        bus_a = 4'h0;
        repeat (15) tick();
        chk("t5_pre_bus", bus_o, 4'h0);
        cnt_a = 0;
        bus_a = 4'h6;
        repeat (3) begin tick(); cnt_a += int'(bus_valid_o); end
        bus_a = 4'h0;
        repeat (15) begin tick(); cnt_a += int'(bus_valid_o); end
        chk("t5_no_pulse", cnt_a, 0);
        chk("t5_bus",      bus_o, 4'h0);

        // 6: async reset mid-settle
        bus_a = 4'hC; lvl_a = 8'hF0;
        repeat (4) tick();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t6_level",  level_o, 0);
        chk("t6_rise",   rise_o, 0);
        chk("t6_fall",   fall_o, 0);
        chk("t6_bus",    bus_o, RESET_BUS);
        chk("t6_valid",  bus_valid_o, 0);
        chk("t6_settle", bus_settling_o, 0);
        bus_a = 4'h0; lvl_a = 8'h00;
        repeat (3) tick();
        rst_n = 1'b1;
        cnt_a = 0; cnt_b = 0;
        repeat (12) begin
            tick();
            cnt_a += int'(bus_valid_o);
            cnt_b += $countones(rise_o | fall_o);
        end
        chk("t6_no_valid",  cnt_a, 0);
        chk("t6_no_edges",  cnt_b, 0);
        chk("t6_bus_after", bus_o, RESET_BUS);

        // randomized phase, model-checked every cycle
        for (int i = 0; i < 500; i++) begin
            for (int k = 0; k < WIDTH; k++)
                if ($urandom_range(3) == 0) lvl_a[k] = ~lvl_a[k];
            if ($urandom_range(7) == 0) bus_a = 4'($urandom_range(15));
            tick();
        end

        // input held high through reset yields a rise after release
        lvl_a = 8'hAA;
        repeat (4) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        cnt_a = 0;
        repeat (10) begin tick(); cnt_a += int'(rise_o[1]); end
        chk("t7_rise_after_rst", cnt_a, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
